// File: rtl/lab4_branch_branchpredarbiter_if.sv
// Handshake bundle between fetch/execute and the predictor arbiter:
// predict request, prediction response and resolution update channels.
interface lab4_branch_branchpredarbiter_if;
    logic        pred_req_val;
    logic        pred_req_rdy;
    logic [31:0] pred_req_pc;
    logic        pred_resp_val;
    logic        pred_resp_rdy;
    logic        pred_resp_taken;
    logic        upd_req_val;
    logic        upd_req_rdy;
    logic [31:0] upd_req_pc;
    logic        upd_req_taken;
    logic        upd_req_pred;

    modport master (
        output pred_req_val, pred_req_pc, pred_resp_rdy,
               upd_req_val, upd_req_pc, upd_req_taken, upd_req_pred,
        input  pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy
    );

    modport slave (
        input  pred_req_val, pred_req_pc, pred_resp_rdy,
               upd_req_val, upd_req_pc, upd_req_taken, upd_req_pred,
        output pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy
    );
endinterface

// File: rtl/lab4_branch_branchpredarbiter.sv
// Shares the single gshare PC port between fetch predictions and queued
// execute-side updates, with bounded prediction starvation and statistics.
module lab4_branch_branchpredarbiter #(
    parameter int p_upd_depth = 2,
    parameter int p_max_wait  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    lab4_branch_branchpredarbiter_if.slave bus,
    output logic [31:0]                    bp_pc,
    output logic                           bp_update_en,
    output logic                           bp_update_val,
    input  logic                           bp_prediction,
    output logic [31:0]                    num_updates,
    output logic [31:0]                    num_mispred
);
    localparam int               PTR_W    = (p_upd_depth > 1) ? $clog2(p_upd_depth) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [3:0]       MAX_WAIT = 4'(p_max_wait);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(p_upd_depth);

    logic [31:0]      q_pc    [p_upd_depth];
    logic             q_taken [p_upd_depth];
    logic             q_pred  [p_upd_depth];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] q_cnt;
    logic [3:0]       wait_cnt;
    logic             resp_vld_p1;
    logic             resp_taken_p1;

    logic q_empty;
    logic resp_space;
    logic grant_p;
    logic grant_u;
    logic enq;

    // Updates win by default so predictions see current history; the wait
    // counter forces a pending prediction through once it saturates.
    always_comb begin
        q_empty    = (q_cnt == '0);
        resp_space = !resp_vld_p1 || bus.pred_resp_rdy;
        grant_p    = !reset && bus.pred_req_val && resp_space &&
                     (q_empty || (wait_cnt == MAX_WAIT));
        grant_u    = !reset && !grant_p && !q_empty;
        enq        = !reset && bus.upd_req_val && (q_cnt < DEPTH);
    end

    assign bus.pred_req_rdy    = grant_p;
    assign bus.upd_req_rdy     = !reset && (q_cnt < DEPTH);
    assign bus.pred_resp_val   = !reset && resp_vld_p1;
    assign bus.pred_resp_taken = resp_taken_p1;
    assign bp_pc               = grant_u ? q_pc[rd_ptr] : bus.pred_req_pc;
    assign bp_update_en        = grant_u;
    assign bp_update_val       = q_taken[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_cnt       <= '0;
            wait_cnt    <= '0;
            resp_vld_p1 <= 1'b0;
            num_updates <= '0;
            num_mispred <= '0;
        end else begin
            if (enq)     wr_ptr <= wr_ptr + 1'b1;
            if (grant_u) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, grant_u})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: ;
            endcase

            if (grant_p || !bus.pred_req_val) wait_cnt <= '0;
            else if (wait_cnt != MAX_WAIT)    wait_cnt <= wait_cnt + 1'b1;

            if (grant_p)                resp_vld_p1 <= 1'b1;
            else if (bus.pred_resp_rdy) resp_vld_p1 <= 1'b0;

            if (grant_u) begin
                num_updates <= num_updates + 32'd1;
                if (q_taken[rd_ptr] != q_pred[rd_ptr]) num_mispred <= num_mispred + 32'd1;
            end
        end
    end

    // ---- stage p0 -> p1: queue storage and response capture ----
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]    <= bus.upd_req_pc;
            q_taken[wr_ptr] <= bus.upd_req_taken;
            q_pred[wr_ptr]  <= bus.upd_req_pred;
        end
        if (grant_p) resp_taken_p1 <= bp_prediction;
    end
endmodule

// File: tb/tb_lab4_branch_branchpredarbiter.sv
// Directed bench for the predictor arbiter with scoreboards for responses and updates.
`timescale 1ns/1ps
module tb_lab4_branch_branchpredarbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bp_pc;
    logic        bp_update_en;
    logic        bp_update_val;
    logic        bp_prediction;
    logic [31:0] num_updates;
    logic [31:0] num_mispred;

    lab4_branch_branchpredarbiter_if bus();

    lab4_branch_branchpredarbiter #(.p_upd_depth(2), .p_max_wait(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .bp_pc(bp_pc), .bp_update_en(bp_update_en), .bp_update_val(bp_update_val),
        .bp_prediction(bp_prediction), .num_updates(num_updates), .num_mispred(num_mispred)
    );

    always #5 clk = ~clk;

    function automatic logic model(input logic [31:0] pc);
        return pc[8] ^ pc[2];
    endfunction

    assign bp_prediction = model(bp_pc);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
    } upd_t;

    upd_t upd_sb[$];
    logic pred_sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_upd = 0;
    int   exp_mis = 0;
    int   n_upd_pulses = 0;
    int   pulses_before = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle at the falling edge and run the scoreboards.
    task automatic cyc();
        upd_t u;
        logic p;
        @(negedge clk);
        if (reset) begin
            upd_sb.delete();
            pred_sb.delete();
            exp_upd = 0;
            exp_mis = 0;
        end else begin
            if (bp_update_en) begin
                n_upd_pulses++;
                chk("upd_sb_nonempty", 32'(upd_sb.size() != 0), 1);
                chk("upd_excl_pred_rdy", bus.pred_req_rdy, 0);
                if (upd_sb.size() != 0) begin
                    u = upd_sb.pop_front();
                    chk("bp_pc_upd", bp_pc, u.pc);
                    chk("bp_update_val", bp_update_val, u.taken);
                    exp_upd++;
                    if (u.taken != u.pred) exp_mis++;
                end
            end
            if (bus.pred_resp_val && bus.pred_resp_rdy) begin
                chk("resp_sb_nonempty", 32'(pred_sb.size() != 0), 1);
                if (pred_sb.size() != 0) begin
                    p = pred_sb.pop_front();
                    chk("resp_taken", bus.pred_resp_taken, p);
                end
            end
            if (bus.pred_req_val && bus.pred_req_rdy) pred_sb.push_back(model(bus.pred_req_pc));
            if (bus.upd_req_val && bus.upd_req_rdy) begin
                u = '{pc: bus.upd_req_pc, taken: bus.upd_req_taken, pred: bus.upd_req_pred};
                upd_sb.push_back(u);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_req_val  = 1'b0;
        bus.pred_req_pc   = '0;
        bus.upd_req_val   = 1'b0;
        bus.upd_req_pc    = '0;
        bus.upd_req_taken = 1'b0;
        bus.upd_req_pred  = 1'b0;
    endtask

    // Keeps the queue non-empty while one predict stays pending; the predict
    // must lose four cycles and be forced through on the fifth.
    task automatic starve(input logic [31:0] base);
        bus.upd_req_val   = 1'b1;
        bus.upd_req_pc    = base;
        bus.upd_req_taken = 1'b0;
        bus.upd_req_pred  = 1'b1;
        cyc();
        adv();
        bus.pred_req_val = 1'b1;
        bus.pred_req_pc  = 32'h500;
        for (int i = 1; i <= 4; i++) begin
            bus.upd_req_pc    = base + 32'(4 * i);
            bus.upd_req_taken = i[0];
            bus.upd_req_pred  = i[1];
            cyc();
            chk("starve_upd_wins", bp_update_en, 1);
            chk("starve_pred_held", bus.pred_req_rdy, 0);
            adv();
        end
        bus.upd_req_pc    = base + 32'd20;
        bus.upd_req_taken = 1'b1;
        bus.upd_req_pred  = 1'b1;
        cyc();
        chk("starve_forced_grant", bus.pred_req_rdy, 1);
        chk("starve_no_upd", bp_update_en, 0);
        adv();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.pred_resp_rdy = 1'b1;
        bus.pred_req_val  = 1'b1;
        bus.pred_req_pc   = 32'h100;
        bus.upd_req_val   = 1'b1;
        bus.upd_req_pc    = 32'h44;
        adv();
        cyc();
        chk("rst_pred_req_rdy", bus.pred_req_rdy, 0);
        chk("rst_upd_req_rdy", bus.upd_req_rdy, 0);
        chk("rst_pred_resp_val", bus.pred_resp_val, 0);
        chk("rst_bp_update_en", bp_update_en, 0);
        chk("rst_num_updates", num_updates, 0);
        chk("rst_num_mispred", num_mispred, 0);
        adv();

        // single predict, empty queue
        reset = 1'b0;
        idle();
        bus.pred_req_val = 1'b1;
        bus.pred_req_pc  = 32'h100;
        cyc();
        chk("t1_pred_req_rdy", bus.pred_req_rdy, 1);
        adv();
        bus.pred_req_val = 1'b0;
        cyc();
        chk("t1_resp_val", bus.pred_resp_val, 1);
        chk("t1_resp_taken", bus.pred_resp_taken, 1);
        adv();
        chk("t1_no_update", 32'(n_upd_pulses), 0);

        // one update then three back-to-back predicts
        bus.upd_req_val   = 1'b1;
        bus.upd_req_pc    = 32'h200;
        bus.upd_req_taken = 1'b1;
        bus.upd_req_pred  = 1'b0;
        cyc();
        chk("t2_upd_rdy", bus.upd_req_rdy, 1);
        chk("t2_c0_no_upd", bp_update_en, 0);
        adv();
        bus.upd_req_val  = 1'b0;
        bus.pred_req_val = 1'b1;
        bus.pred_req_pc  = 32'h104;
        cyc();
        chk("t2_c1_upd_en", bp_update_en, 1);
        chk("t2_c1_pred_rdy", bus.pred_req_rdy, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            bus.pred_req_pc = 32'h104 + 32'(4 * i);
            cyc();
            chk("t2_pred_grant", bus.pred_req_rdy, 1);
            adv();
        end
        bus.pred_req_val = 1'b0;
        cyc();
        adv();
        chk("t2_num_updates", num_updates, 1);
        chk("t2_num_mispred", num_mispred, 1);

        // starvation bound, queue fill and held third update
        starve(32'h300);
        bus.pred_req_val  = 1'b0;
        bus.upd_req_pc    = 32'h318;
        bus.upd_req_taken = 1'b0;
        bus.upd_req_pred  = 1'b0;
        cyc();
        chk("t4_upd_rdy_full", bus.upd_req_rdy, 0);
        chk("t4_wait_cleared", 32'(dut.wait_cnt), 0);
        chk("t4_drain_upd", bp_update_en, 1);
        adv();
        cyc();
        chk("t4_held_accepted", bus.upd_req_rdy, 1);
        adv();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            adv();
        end
        chk("t4_queue_drained", 32'(upd_sb.size()), 0);
        chk("t4_num_updates", num_updates, 32'(exp_upd));
        chk("t4_num_mispred", num_mispred, 32'(exp_mis));

        // response backpressure
        bus.pred_resp_rdy = 1'b0;
        bus.pred_req_val  = 1'b1;
        bus.pred_req_pc   = 32'h600;
        cyc();
        chk("t5_first_accept", bus.pred_req_rdy, 1);
        adv();
        bus.pred_req_pc = 32'h604;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t5_blocked", bus.pred_req_rdy, 0);
            chk("t5_resp_held", bus.pred_resp_val, 1);
            adv();
        end
        bus.pred_resp_rdy = 1'b1;
        cyc();
        chk("t5_accept_on_deq", bus.pred_req_rdy, 1);
        adv();
        bus.pred_req_val = 1'b0;
        cyc();
        chk("t5_new_resp_val", bus.pred_resp_val, 1);
        chk("t5_new_resp_taken", bus.pred_resp_taken, 1);
        adv();

        // reset with two queued updates and a buffered response
        starve(32'h700);
        idle();
        bus.pred_resp_rdy = 1'b0;
        reset = 1'b1;
        pulses_before = n_upd_pulses;
        cyc();
        chk("t6_rst_resp_val", bus.pred_resp_val, 0);
        chk("t6_rst_upd_rdy", bus.upd_req_rdy, 0);
        chk("t6_rst_pred_rdy", bus.pred_req_rdy, 0);
        chk("t6_rst_upd_en", bp_update_en, 0);
        adv();
        reset = 1'b0;
        bus.pred_resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_no_upd_after_rst", bp_update_en, 0);
            chk("t6_resp_val_low", bus.pred_resp_val, 0);
            adv();
        end
        chk("t6_num_updates", num_updates, 0);
        chk("t6_num_mispred", num_mispred, 0);
        chk("t6_pulse_count", 32'(n_upd_pulses), 32'(pulses_before));
        chk("sb_empty", 32'(upd_sb.size() + pred_sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
